alu_issue_ctrl: RTL and testbench

Sequencer directly upstream of the 4-bit combinational ALU (ports A, B, opcode, result, carry).
- Accepts packed instructions over a valid/ready handshake and reads operands from a 4-entry x 4-bit register file.
- Drives the ALU inputs, captures result and carry, and writes the result back.
- Provides the register storage and ordering the bare ALU lacks; the ALU itself is instantiated outside this block.

---
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequencer in front of a 4-bit combinational ALU. Accepts packed
//   instructions {op[8:6], rd[5:4], rs1[3:2], rs2[1:0]} over valid/ready,
//   reads operands from a small register file, drives the external ALU,
//   captures result/carry and writes the result back.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   instr_valid/instr_ready   instruction handshake (ready is registered)
//   instr                     packed instruction
//   alu_a/alu_b/alu_op        registered ALU operands and opcode
//   alu_result/alu_carry      combinational ALU outputs
//   wb_valid/wb_rd/wb_data    one-cycle retirement pulse, rd and data held
//   carry_flag                carry of the last ALU (non-LOADI) instruction
//   retire_cnt                saturating retirement count (ALU_ISSUE_CNT_EN only)
//
// Build option
//   ALU_ISSUE_CNT_EN : adds retire_cnt output and its 8-bit saturating counter.
//
// state | meaning
// IDLE  | instr_ready high, waiting for a transfer
// READ  | operands read from register file onto ALU inputs
// EXEC  | ALU inputs stable, result/carry captured
// WB    | result written to rd, wb_valid pulsed

module alu_issue_ctrl #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [8:0]        instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              wb_valid,
  output logic [1:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              carry_flag
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [7:0]        retire_cnt
`endif
);

  localparam logic [2:0] OP_LOADI = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic [1:0]        rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] res_q;
  logic              carry_q;
  logic [DATA_W-1:0] res_d;
  logic              is_loadi;

  assign is_loadi = (op_q == OP_LOADI);

  // LOADI carries its immediate in the rs1/rs2 fields, zero-extended.
  assign res_d = is_loadi ? DATA_W'({rs1_q, rs2_q}) : alu_result;

`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] cnt_d;
  assign cnt_d = (retire_cnt == 8'hFF) ? retire_cnt : retire_cnt + 8'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_ready <= 1'b1;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      regs_q      <= '{default: '0};
      res_q       <= '0;
      carry_q     <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      carry_flag  <= 1'b0;
`ifdef ALU_ISSUE_CNT_EN
      retire_cnt  <= '0;
`endif
    end else begin
      wb_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q        <= instr[8:6];
            rd_q        <= instr[5:4];
            rs1_q       <= instr[3:2];
            rs2_q       <= instr[1:0];
            instr_ready <= 1'b0;
            state_q     <= READ;
          end
        end
        READ: begin
          // LOADI leaves the ALU inputs at their previous values.
          if (!is_loadi) begin
            alu_a  <= regs_q[rs1_q];
            alu_b  <= regs_q[rs2_q];
            alu_op <= op_q;
          end
          state_q <= EXEC;
        end
        EXEC: begin
          res_q <= res_d;
          if (!is_loadi) carry_q <= alu_carry;
          state_q <= WB;
        end
        WB: begin
          regs_q[rd_q] <= res_q;
          wb_valid     <= 1'b1;
          wb_rd        <= rd_q;
          wb_data      <= res_q;
          if (!is_loadi) carry_flag <= carry_q;
`ifdef ALU_ISSUE_CNT_EN
          retire_cnt   <= cnt_d;
`endif
          instr_ready  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [3:0] wb_data;
  logic       carry_flag;
`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] retire_cnt;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  alu_issue_ctrl #(.DATA_W(4), .NREGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .carry_flag  (carry_flag)
`ifdef ALU_ISSUE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: carry is add carry-out, or borrow for subtract.
  always_comb begin
    alu_result = 4'd0;
    alu_carry  = 1'b0;
    case (alu_op)
      3'b000: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~alu_a;
      3'b110: alu_result = alu_a >> 1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One instruction through the pipe; accept edge N, wb_valid after edge N+3,
  // then one more cycle to confirm the pulse drops and data holds.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [3:0] ea, input logic [3:0] eb,
                       input logic [2:0] eop, input logic [3:0] edata, input logic ecarry,
                       input string tag);
    @(negedge clk);
    instr       = {op, rd, rs1, rs2};
    instr_valid = 1'b1;
    chk({tag, "_ready_idle"}, instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = 9'($urandom);
    chk({tag, "_ready_read"}, instr_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_alu_a"}, alu_a, ea);
    chk({tag, "_alu_b"}, alu_b, eb);
    chk({tag, "_alu_op"}, alu_op, eop);
    @(posedge clk); #1;
    chk({tag, "_alu_a_exec"}, alu_a, ea);
    chk({tag, "_alu_b_exec"}, alu_b, eb);
    chk({tag, "_wbv_early"}, wb_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_wb_rd"}, wb_rd, rd);
    chk({tag, "_wb_data"}, wb_data, edata);
    chk({tag, "_carry"}, carry_flag, ecarry);
    @(posedge clk); #1;
    chk({tag, "_wbv_drop"}, wb_valid, 0);
    chk({tag, "_wb_hold"}, wb_data, edata);
  endtask

  logic [8:0] bb_instr [3];
  logic [3:0] bb_data  [3];

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    bb_instr    = '{9'b111_11_00_01, 9'b000_11_11_11, 9'b000_11_11_11};
    bb_data     = '{4'd1, 4'd2, 4'd4};

    repeat (2) @(posedge clk); #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
`ifdef ALU_ISSUE_CNT_EN
    chk("rst_cnt", retire_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", instr_ready, 1);

    // LOADI r0=4, r1=3, ADD r2
    issue(3'b111, 2'd0, 2'b01, 2'b00, 4'd0, 4'd0, 3'd0, 4'd4, 1'b0, "t1_ldi_r0");
    issue(3'b111, 2'd1, 2'b00, 2'b11, 4'd0, 4'd0, 3'd0, 4'd3, 1'b0, "t1_ldi_r1");
    issue(3'b000, 2'd2, 2'd0,  2'd1,  4'd4, 4'd3, 3'd0, 4'd7, 1'b0, "t1_add");

    // 9 + 8 overflows, LOADI keeps the carry
    issue(3'b111, 2'd0, 2'b10, 2'b01, 4'd4, 4'd3, 3'd0, 4'd9, 1'b0, "t2_ldi_r0");
    issue(3'b111, 2'd1, 2'b10, 2'b00, 4'd4, 4'd3, 3'd0, 4'd8, 1'b0, "t2_ldi_r1");
    issue(3'b000, 2'd3, 2'd0,  2'd1,  4'd9, 4'd8, 3'd0, 4'd1, 1'b1, "t2_add");
    issue(3'b111, 2'd0, 2'b00, 2'b10, 4'd9, 4'd8, 3'd0, 4'd2, 1'b1, "t2_ldi_keep");

    // rd = rs1 = rs2: r3 = 1 + 1
    issue(3'b000, 2'd3, 2'd3, 2'd3, 4'd1, 4'd1, 3'd0, 4'd2, 1'b0, "t_same_reg");

    // r0=7, r1=2 through SUB/AND/OR/XOR
    issue(3'b111, 2'd0, 2'b01, 2'b11, 4'd1, 4'd1, 3'd0, 4'd7, 1'b0, "t4_ldi_r0");
    issue(3'b111, 2'd1, 2'b00, 2'b10, 4'd1, 4'd1, 3'd0, 4'd2, 1'b0, "t4_ldi_r1");
    issue(3'b001, 2'd2, 2'd0, 2'd1, 4'd7, 4'd2, 3'd1, 4'd5,  1'b0, "t4_sub");
    issue(3'b001, 2'd2, 2'd1, 2'd0, 4'd2, 4'd7, 3'd1, 4'd11, 1'b1, "t4_sub_borrow");
    issue(3'b010, 2'd2, 2'd0, 2'd1, 4'd7, 4'd2, 3'd2, 4'd2,  1'b0, "t4_and");
    issue(3'b011, 2'd2, 2'd0, 2'd1, 4'd7, 4'd2, 3'd3, 4'd7,  1'b0, "t4_or");
    issue(3'b100, 2'd2, 2'd0, 2'd1, 4'd7, 4'd2, 3'd4, 4'd5,  1'b0, "t4_xor");

    // Back-to-back with instr_valid held: LOADI r3=1, r3+=r3, r3+=r3
    @(negedge clk);
    instr       = bb_instr[0];
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k < 2) instr = bb_instr[k+1];
      else instr_valid = 1'b0;
      chk($sformatf("bb%0d_ready_read", k), instr_ready, 0);
      chk($sformatf("bb%0d_wbv_read", k), wb_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("bb%0d_ready_exec", k), instr_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("bb%0d_ready_wb", k), instr_ready, 0);
      chk($sformatf("bb%0d_wbv_early", k), wb_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("bb%0d_wbv", k), wb_valid, 1);
      chk($sformatf("bb%0d_wb_data", k), wb_data, bb_data[k]);
      chk($sformatf("bb%0d_ready_idle", k), instr_ready, 1);
    end
    repeat (5) begin
      @(posedge clk); #1;
      chk("bb_no_extra_wb", wb_valid, 0);
    end

    // Reset during EXEC aborts the ADD and clears the register file
    issue(3'b111, 2'd0, 2'b01, 2'b01, 4'd2, 4'd2, 3'd0, 4'd5, 1'b0, "t5_ldi_r0");
    issue(3'b111, 2'd1, 2'b01, 2'b10, 4'd2, 4'd2, 3'd0, 4'd6, 1'b0, "t5_ldi_r1");
    @(negedge clk);
    instr       = {3'b000, 2'd2, 2'd0, 2'd1};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("t5_ready_read", instr_ready, 0);
    @(posedge clk); #1;
    chk("t5_alu_a_exec", alu_a, 5);
    chk("t5_alu_b_exec", alu_b, 6);
    rst = 1'b1;
    #1;
    chk("t5_rst_wbv", wb_valid, 0);
    chk("t5_rst_ready", instr_ready, 1);
    chk("t5_rst_alu_a", alu_a, 0);
    chk("t5_rst_alu_b", alu_b, 0);
    chk("t5_rst_wb_rd", wb_rd, 0);
    chk("t5_rst_wb_data", wb_data, 0);
    @(posedge clk); #1;
    chk("t5_rst_no_wb", wb_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_ready_after_release", instr_ready, 1);
    chk("t5_no_wb_after_release", wb_valid, 0);
    issue(3'b000, 2'd2, 2'd0, 2'd1, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0, "t5_add_r0r1");
    issue(3'b000, 2'd3, 2'd2, 2'd3, 4'd0, 4'd0, 3'd0, 4'd0, 1'b0, "t5_add_r2r3");

`ifdef ALU_ISSUE_CNT_EN
    // 260 back-to-back LOADIs saturate the retirement counter
    @(negedge clk);
    rst = 1'b1;
    #1 chk("cnt_rst", retire_cnt, 0);
    @(negedge clk);
    rst         = 1'b0;
    instr       = 9'b111_00_00_01;
    instr_valid = 1'b1;
    repeat (1040) @(posedge clk);
    #1;
    chk("cnt_sat", retire_cnt, 255);
    instr_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("cnt_hold", retire_cnt, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
